// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a WIDTH-bit shifting register: runs load/shift/rotate commands and returns the result.
// Optional register-activity counter on port pwr_cnt is enabled by defining SRC_PWR_CNT_EN.
module shift_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int PWR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_sin,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SRC_PWR_CNT_EN
    ,
    output logic [PWR_W-1:0] pwr_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_CAPT  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t             state_r, state_s;
    logic [1:0]         op_r, op_s;
    logic [CNT_W-1:0]   rem_r, rem_s;
    logic [WIDTH-1:0]   data_r, data_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   result_r, result_s;

    // State and latched-command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_LOAD;
            rem_r    <= CNT_ZERO;
            data_r   <= DATA_ZERO;
            done_r   <= 1'b0;
            result_r <= DATA_ZERO;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            rem_r    <= rem_s;
            data_r   <= data_s;
            done_r   <= done_s;
            result_r <= result_s;
        end
    end

    // Next-state, command latch and result capture
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        rem_s    = rem_r;
        data_s   = data_r;
        done_s   = 1'b0;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_s   = cmd_op;
                    data_s = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        state_s = ST_LOAD;
                        rem_s   = CNT_ZERO;
                    end else if (cmd_cnt == CNT_ZERO) begin
                        state_s = ST_CAPT;
                        rem_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_SHIFT;
                        rem_s   = cmd_cnt;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_CAPT;
            end
            ST_SHIFT: begin
                rem_s = rem_r - CNT_ONE;
                if (rem_r == CNT_ONE) begin
                    state_s = ST_CAPT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_CAPT: begin
                result_s = sr_q;
                done_s   = 1'b1;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                rem_s   = CNT_ZERO;
            end
        endcase
    end

    // Moore decode of register control lines; only the rotate feedback looks at sr_q
    always_comb begin
        sr_mode   = MODE_HOLD;
        sr_din    = DATA_ZERO;
        sr_sin    = 1'b0;
        busy      = 1'b1;
        cmd_ready = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                sr_mode = MODE_LOAD;
                sr_din  = data_r;
            end
            ST_SHIFT: begin
                if (op_r == OP_SHL) begin
                    sr_mode = MODE_LEFT;
                end else begin
                    sr_mode = MODE_RIGHT;
                end
                if (op_r == OP_ROR) begin
                    sr_sin = sr_q[0];
                end else begin
                    sr_sin = 1'b0;
                end
            end
            ST_CAPT: begin
                sr_mode = MODE_HOLD;
            end
            default: begin
                sr_mode = MODE_HOLD;
            end
        endcase
    end

    assign done   = done_r;
    assign result = result_r;

`ifdef SRC_PWR_CNT_EN
    localparam logic [PWR_W-1:0] PWR_MAX = {PWR_W{1'b1}};
    localparam logic [PWR_W-1:0] PWR_ONE = {{(PWR_W-1){1'b0}}, 1'b1};

    logic [PWR_W-1:0] pwr_r;

    // Saturating count of edges on which the register is not holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_r <= {PWR_W{1'b0}};
        end else if ((sr_mode != MODE_HOLD) && (pwr_r != PWR_MAX)) begin
            pwr_r <= pwr_r + PWR_ONE;
        end else begin
            pwr_r <= pwr_r;
        end
    end

    assign pwr_cnt = pwr_r;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl with a behavioural model of the external shift register.
// Define SRC_PWR_CNT_EN to also check the activity counter.
module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic [1:0] sr_mode;
    logic [3:0] sr_din;
    logic       sr_sin;
    logic [3:0] sr_q;
    logic       busy;
    logic       done;
    logic [3:0] result;
`ifdef SRC_PWR_CNT_EN
    logic [15:0] pwr_cnt;
`endif

    logic [3:0] model_q = 4'b0000;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        logic [3:0] exp_result;
        int         exp_lat;
        logic [1:0] exp_mode;
        int         exp_active;
    } vec_t;

    vec_t vecs[12];

    shift_reg_ctrl #(.WIDTH(4), .CNT_W(3), .PWR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .sr_mode   (sr_mode),
        .sr_din    (sr_din),
        .sr_sin    (sr_sin),
        .sr_q      (sr_q),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef SRC_PWR_CNT_EN
        ,
        .pwr_cnt   (pwr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model of the controlled register (not reset: it simply holds)
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   model_q <= {sr_sin, model_q[3:1]};
            2'b10:   model_q <= {model_q[2:0], sr_sin};
            2'b11:   model_q <= sr_din;
            default: model_q <= model_q;
        endcase
    end
    assign sr_q = model_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, scramble inputs after acceptance, and check it end to end
    task automatic run_vec(input int idx, input vec_t v);
        int waited = 0;
        int lat = 0;
        int active = 0;
        int mode_err = 0;
        int din_err = 0;
        int sin_err = 0;
        logic [3:0] res = 4'b0000;
        logic exp_sin;
        while (!cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_cnt   = v.cnt;
        cmd_data  = v.data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_cnt   = 3'($urandom_range(0, 7));
        cmd_data  = ~v.data;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                lat = i;
                res = result;
                break;
            end
            if (sr_mode != 2'b00) begin
                active++;
                if (sr_mode != v.exp_mode) mode_err++;
            end
            if (sr_mode == 2'b11) begin
                if (sr_din != v.data) din_err++;
            end else if (sr_din != 4'b0000) begin
                din_err++;
            end
            exp_sin = (v.op == 2'b11 && sr_mode != 2'b00) ? model_q[0] : 1'b0;
            if (sr_sin != exp_sin) sin_err++;
            tick();
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_result", idx), {28'd0, res}, {28'd0, v.exp_result});
        check($sformatf("v%0d_active_cycles", idx), active, v.exp_active);
        check($sformatf("v%0d_mode_errs", idx), mode_err, 0);
        check($sformatf("v%0d_din_errs", idx), din_err, 0);
        check($sformatf("v%0d_sin_errs", idx), sin_err, 0);
        tick();
        check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int lat;
        int done_seen;
        logic [3:0] q_hold;

        vecs[0]  = '{2'b00, 3'd0, 4'b1010, 4'b1010, 3, 2'b11, 1};
        vecs[1]  = '{2'b00, 3'd0, 4'b1011, 4'b1011, 3, 2'b11, 1};
        vecs[2]  = '{2'b01, 3'd3, 4'b1111, 4'b0001, 5, 2'b01, 3};
        vecs[3]  = '{2'b00, 3'd0, 4'b1011, 4'b1011, 3, 2'b11, 1};
        vecs[4]  = '{2'b11, 3'd1, 4'b0000, 4'b1101, 3, 2'b01, 1};
        vecs[5]  = '{2'b10, 3'd2, 4'b0000, 4'b0100, 4, 2'b10, 2};
        vecs[6]  = '{2'b10, 3'd0, 4'b1111, 4'b0100, 2, 2'b00, 0};
        vecs[7]  = '{2'b11, 3'd4, 4'b0000, 4'b0100, 6, 2'b01, 4};
        vecs[8]  = '{2'b00, 3'd0, 4'b0110, 4'b0110, 3, 2'b11, 1};
        vecs[9]  = '{2'b11, 3'd7, 4'b0000, 4'b1100, 9, 2'b01, 7};
        vecs[10] = '{2'b01, 3'd7, 4'b0000, 4'b0000, 9, 2'b01, 7};
        vecs[11] = '{2'b01, 3'd0, 4'b0000, 4'b0000, 2, 2'b00, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 3'd0;
        cmd_data  = 4'b0000;
        tick();
        tick();
        check("rst_mode", {30'd0, sr_mode}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_din", {28'd0, sr_din}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a cnt=5 shift after loading 1111
        run_vec(100, '{2'b00, 3'd0, 4'b1111, 4'b1111, 3, 2'b11, 1});
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd5;
        cmd_data  = 4'b0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        q_hold = model_q;
        check("arst_mode", {30'd0, sr_mode}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", {28'd0, result}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_rel_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_rel_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("arst_no_done", done_seen, 0);
        check("arst_reg_held", {28'd0, model_q}, {28'd0, q_hold});

        // B held valid while A runs; B accepted on the edge that clears done
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_cnt   = 3'd0;
        cmd_data  = 4'b1001;
        tick();
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd1;
        cmd_data  = 4'b0000;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
        check("hs_a_latency", lat, 3);
        check("hs_a_result", {28'd0, result}, {28'd0, 4'b1001});
        check("hs_a_ready_at_done", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("hs_b_done_cleared", {31'd0, done}, 32'd0);
        check("hs_b_accepted", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
        check("hs_b_latency", lat, 3);
        check("hs_b_result", {28'd0, result}, {28'd0, 4'b0100});

`ifdef SRC_PWR_CNT_EN
        #3;
        rst_n = 1'b0;
        #1;
        check("pwr_rst", {16'd0, pwr_cnt}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_vec(200, '{2'b00, 3'd0, 4'b0011, 4'b0011, 3, 2'b11, 1});
        run_vec(201, '{2'b01, 3'd3, 4'b0000, 4'b0000, 5, 2'b01, 3});
        check("pwr_count", {16'd0, pwr_cnt}, 32'd4);
`endif

        n = n_err;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n);
        $finish;
    end

endmodule
